// File: rtl/muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue
// Purpose  : EX-stage issue side of the multicycle multiply/divide unit.
//            Decodes HI/LO-class requests, drives start/annul/operands to
//            the arithmetic unit, stalls the pipe while it works, and commits
//            the 64-bit result into HI/LO. Handles MTHI/MTLO, divide-by-zero
//            bypass, flush and a ready-timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        md_start_o,
  output logic        md_annul_o,
  output logic        md_sel_mul_div_o,
  output logic        md_signed_o,
  output logic [31:0] md_opdata1_o,
  output logic [31:0] md_opdata2_o,
  input  logic [63:0] md_result_i,
  input  logic        md_ready_i
);

  localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
  localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);
  localparam logic [2:0]        c_OP_MTHI = 3'b100;
  localparam logic [2:0]        c_OP_MTLO = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_done;
  logic                r_err;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic                r_start;
  logic                r_annul;
  logic                r_sel;
  logic                r_signed;
  logic [31:0]         r_op1;
  logic [31:0]         r_op2;
  logic [c_WD_W-1:0]   r_wdog;

  logic                w_is_md;
  logic                w_div0;
  logic                w_req;
  logic                w_issue;
  logic                w_div0_ret;
  logic                w_mthi;
  logic                w_mtlo;
  logic                w_timeout;
  logic                w_abort;
  logic                w_commit;

  // Request decode, retire/abort conditions, next state and the stall output
  always_comb begin
    w_is_md     = ~op_i[2];
    w_div0      = op_i[1] & (rt_data_i == 32'd0);
    w_req       = req_valid_i & ~flush_i & (r_state == S_IDLE);
    w_issue     = w_req & w_is_md & ~w_div0;
    w_div0_ret  = w_req & w_is_md & w_div0;
    w_mthi      = w_req & (op_i == c_OP_MTHI);
    w_mtlo      = w_req & (op_i == c_OP_MTLO);
    // Ready on the last watchdog cycle still commits; only a missing ready times out
    w_timeout   = (r_state == S_BUSY) & (r_wdog == c_WD_LAST) & ~md_ready_i;
    // Flush takes priority over a coincident ready
    w_abort     = (r_state == S_BUSY) & (flush_i | w_timeout);
    w_commit    = (r_state == S_BUSY) & md_ready_i & ~flush_i;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_commit | w_abort) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    stall_o = w_issue | ((r_state == S_BUSY) & ~md_ready_i & ~flush_i);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Unit controls, latched operands, HI/LO, status pulses and watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_start  <= 1'b0;
      r_annul  <= 1'b0;
      r_sel    <= 1'b0;
      r_signed <= 1'b0;
      r_op1    <= 32'd0;
      r_op2    <= 32'd0;
      r_wdog   <= '0;
    end else begin
      r_done  <= w_mthi | w_mtlo | w_div0_ret | w_commit;
      r_annul <= w_abort;

      if (w_timeout) begin
        r_err <= 1'b1;
      end

      // Operands and controls only change on issue, so they stay frozen in BUSY
      if (w_issue) begin
        r_start  <= 1'b1;
        r_sel    <= ~op_i[1];
        r_signed <= ~op_i[0];
        r_op1    <= rs_data_i;
        r_op2    <= rt_data_i;
      end else if (w_commit | w_abort) begin
        r_start  <= 1'b0;
      end

      if (w_mthi) begin
        r_hi <= rs_data_i;
      end
      if (w_mtlo) begin
        r_lo <= rs_data_i;
      end
      if (w_commit) begin
        r_hi <= md_result_i[63:32];
        r_lo <= md_result_i[31:0];
      end

      // Watchdog counts BUSY cycles and always re-enters BUSY from zero
      if ((r_state == S_BUSY) && !(w_commit | w_abort)) begin
        r_wdog <= r_wdog + c_WD_ONE;
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign done_o           = r_done;
  assign err_o            = r_err;
  assign hi_o             = r_hi;
  assign lo_o             = r_lo;
  assign md_start_o       = r_start;
  assign md_annul_o       = r_annul;
  assign md_sel_mul_div_o = r_sel;
  assign md_signed_o      = r_signed;
  assign md_opdata1_o     = r_op1;
  assign md_opdata2_o     = r_op2;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_issue
// Purpose  : Self-checking bench for muldiv_issue. A behavioural arithmetic
//            unit answers start with a configurable latency; expected HI/LO
//            come from plain-arithmetic reference results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue;

  localparam int c_TIMEOUT = 40;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        md_start_o;
  logic        md_annul_o;
  logic        md_sel_mul_div_o;
  logic        md_signed_o;
  logic [31:0] md_opdata1_o;
  logic [31:0] md_opdata2_o;
  logic [63:0] md_result_i;
  logic        md_ready_i;

  int errors;
  int checks;
  int unit_lat;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  int done_cnt;
  int annul_cnt;
  int start_rises;
  int low_run;
  int last_gap;
  logic prev_start;

  typedef struct {
    logic        stall_acc;
    logic        start;
    logic        sel;
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    int          stall_bad;
    bit          seen;
    logic        stall_rdy;
    logic        done_now;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        start_after;
    int          done_delta;
    int          rises;
  } obs_t;

  muldiv_issue #(.TIMEOUT(c_TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .op_i             (op_i),
    .rs_data_i        (rs_data_i),
    .rt_data_i        (rt_data_i),
    .flush_i          (flush_i),
    .stall_o          (stall_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .hi_o             (hi_o),
    .lo_o             (lo_o),
    .md_start_o       (md_start_o),
    .md_annul_o       (md_annul_o),
    .md_sel_mul_div_o (md_sel_mul_div_o),
    .md_signed_o      (md_signed_o),
    .md_opdata1_o     (md_opdata1_o),
    .md_opdata2_o     (md_opdata2_o),
    .md_result_i      (md_result_i),
    .md_ready_i       (md_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: op[1:0] 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; div gives {rem, quo}
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = 64'd0;
    case (op[1:0])
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
      default: if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
    endcase
    return res;
  endfunction

  // Output event counters, sampled mid-cycle
  always @(negedge clk) begin
    if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (md_annul_o === 1'b1) annul_cnt <= annul_cnt + 1;
    if (md_start_o === 1'b1 && prev_start !== 1'b1) begin
      start_rises <= start_rises + 1;
      last_gap    <= low_run;
    end
    low_run    <= (md_start_o === 1'b1) ? 0 : low_run + 1;
    prev_start <= md_start_o;
  end

  // Behavioural arithmetic unit: ready for one cycle unit_lat cycles into start (0 = never)
  initial begin
    int cnt;
    bit fired;
    cnt = 0;
    fired = 1'b0;
    md_ready_i = 1'b0;
    md_result_i = 64'd0;
    forever begin
      @(negedge clk);
      md_ready_i = 1'b0;
      if (md_start_o === 1'b1) begin
        cnt++;
        if (!fired && unit_lat != 0 && cnt == unit_lat) begin
          md_ready_i  = 1'b1;
          md_result_i = ref_md({1'b0, ~md_sel_mul_div_o, ~md_signed_o}, md_opdata1_o, md_opdata2_o);
          fired = 1'b1;
        end
      end else begin
        cnt = 0;
        fired = 1'b0;
      end
    end
  end

  // Presents one request at a negedge and runs it to completion, recording observations
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output obs_t o);
    int d0, s0;
    d0 = done_cnt;
    s0 = start_rises;
    o.stall_bad = 0;
    o.seen      = 1'b0;
    o.stall_rdy = 1'b0;
    req_valid_i = 1'b1;
    op_i        = op;
    rs_data_i   = a;
    rt_data_i   = b;
    #1 o.stall_acc = stall_o;
    @(negedge clk);
    req_valid_i = 1'b0;
    rs_data_i   = $urandom;
    rt_data_i   = $urandom;
    o.start = md_start_o;
    o.sel   = md_sel_mul_div_o;
    o.sgn   = md_signed_o;
    o.op1   = md_opdata1_o;
    o.op2   = md_opdata2_o;
    if (md_start_o === 1'b1) begin
      for (int c = 0; c < 200; c++) begin
        #2;
        if (md_ready_i === 1'b1) begin
          o.seen = 1'b1;
          o.stall_rdy = stall_o;
          break;
        end
        if (stall_o !== 1'b1) o.stall_bad++;
        @(negedge clk);
      end
      @(negedge clk);
    end
    o.done_now    = done_o;
    o.hi          = hi_o;
    o.lo          = lo_o;
    o.start_after = md_start_o;
    @(negedge clk);
    #1;
    o.done_delta = done_cnt - d0;
    o.rises      = start_rises - s0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++; if ({hi_o, lo_o, md_opdata1_o, md_opdata2_o} !== 128'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {hi_o, lo_o, md_opdata1_o, md_opdata2_o}); end
    checks++; if ({done_o, err_o, md_start_o, md_annul_o, md_sel_mul_div_o, md_signed_o, stall_o} !== 7'd0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {done_o, err_o, md_start_o, md_annul_o, md_sel_mul_div_o, md_signed_o, stall_o}); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    obs_t o;
    unit_lat = 34;
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, o);
    checks++; if (o.stall_acc !== 1'b1) begin errors++; $display("FAIL multu_stall_accept: got %b expected 1", o.stall_acc); end
    checks++; if (o.seen !== 1'b1 || o.stall_bad !== 0) begin errors++; $display("FAIL multu_stall_busy: ready=%b low_stall_cycles=%0d expected 1/0", o.seen, o.stall_bad); end
    checks++; if (o.stall_rdy !== 1'b0) begin errors++; $display("FAIL multu_stall_ready: got %b expected 0", o.stall_rdy); end
    checks++; if ({o.start, o.sel, o.sgn} !== 3'b110) begin errors++; $display("FAIL multu_ctrl: got %b expected 110", {o.start, o.sel, o.sgn}); end
    checks++; if ({o.hi, o.lo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu_hilo: got %h expected 00000001fffffffe", {o.hi, o.lo}); end
    checks++; if (o.done_now !== 1'b1 || o.done_delta !== 1) begin errors++; $display("FAIL multu_done: got %b/%0d expected 1/1", o.done_now, o.done_delta); end
    checks++; if (o.start_after !== 1'b0) begin errors++; $display("FAIL multu_start_drop: got %b expected 0", o.start_after); end
    m_hi = 32'h0000_0001;
    m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_div();
    obs_t o;
    unit_lat = 34;
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, o);
    checks++; if ({o.start, o.sel, o.sgn} !== 3'b101) begin errors++; $display("FAIL div_ctrl: got %b expected 101", {o.start, o.sel, o.sgn}); end
    checks++; if ({o.op1, o.op2} !== 64'hFFFF_FFF9_0000_0002) begin errors++; $display("FAIL div_operands: got %h expected fffffff900000002", {o.op1, o.op2}); end
    checks++; if ({o.hi, o.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_hilo: got %h expected fffffffffffffffd", {o.hi, o.lo}); end
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFFD;
  endtask

  task automatic test_div0();
    obs_t o;
    run_op(3'b100, 32'hAAAA_0000, 32'h0, o);
    run_op(3'b101, 32'h0000_BBBB, 32'h0, o);
    checks++; if ({o.hi, o.lo} !== 64'hAAAA_0000_0000_BBBB) begin errors++; $display("FAIL mthi_mtlo_preload: got %h expected aaaa00000000bbbb", {o.hi, o.lo}); end
    run_op(3'b011, 32'h0000_0010, 32'h0, o);
    checks++; if (o.stall_acc !== 1'b0) begin errors++; $display("FAIL div0_stall: got %b expected 0", o.stall_acc); end
    checks++; if (o.rises !== 0) begin errors++; $display("FAIL div0_start: got %0d rises expected 0", o.rises); end
    checks++; if (o.done_now !== 1'b1 || o.done_delta !== 1) begin errors++; $display("FAIL div0_done: got %b/%0d expected 1/1", o.done_now, o.done_delta); end
    checks++; if ({o.hi, o.lo} !== 64'hAAAA_0000_0000_BBBB) begin errors++; $display("FAIL div0_hilo: got %h expected aaaa00000000bbbb", {o.hi, o.lo}); end
    m_hi = 32'hAAAA_0000;
    m_lo = 32'h0000_BBBB;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [63:0] r1, r2;
    int s0;
    unit_lat = 20;
    run_op(3'b100, 32'h1234_5678, 32'h0, o);
    checks++; if (o.hi !== 32'h1234_5678 || o.done_now !== 1'b1) begin errors++; $display("FAIL mthi: got hi=%h done=%b expected 12345678/1", o.hi, o.done_now); end
    m_hi = 32'h1234_5678;
    r1 = ref_md(3'b000, 32'h8000_0003, 32'hFFFF_FFF5);
    r2 = ref_md(3'b000, 32'h0001_2345, 32'h0000_7FFF);
    s0 = start_rises;
    req_valid_i = 1'b1;
    op_i        = 3'b000;
    rs_data_i   = 32'h8000_0003;
    rt_data_i   = 32'hFFFF_FFF5;
    @(negedge clk);
    for (int c = 0; c < 200; c++) begin #2; if (md_ready_i === 1'b1) break; @(negedge clk); end
    @(negedge clk);
    checks++; if ({hi_o, lo_o} !== r1) begin errors++; $display("FAIL b2b_first: got %h expected %h", {hi_o, lo_o}, r1); end
    rs_data_i = 32'h0001_2345;
    rt_data_i = 32'h0000_7FFF;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int c = 0; c < 200; c++) begin #2; if (md_ready_i === 1'b1) break; @(negedge clk); end
    @(negedge clk);
    checks++; if ({hi_o, lo_o} !== r2) begin errors++; $display("FAIL b2b_second: got %h expected %h", {hi_o, lo_o}, r2); end
    #1;
    checks++; if (start_rises - s0 !== 2 || last_gap < 1) begin errors++; $display("FAIL b2b_start_gap: got rises=%0d gap=%0d expected 2/>=1", start_rises - s0, last_gap); end
    m_hi = r2[63:32];
    m_lo = r2[31:0];
    @(negedge clk);
  endtask

  task automatic test_flush(input bit with_ready);
    int a0, d0;
    unit_lat = with_ready ? 10 : 34;
    @(negedge clk);
    a0 = annul_cnt;
    d0 = done_cnt;
    req_valid_i = 1'b1;
    op_i        = 3'b000;
    rs_data_i   = $urandom;
    rt_data_i   = $urandom | 32'd1;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    flush_i = 1'b1;
    #2;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush%0d_stall: got %b expected 0", with_ready, stall_o); end
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if ({md_annul_o, md_start_o} !== 2'b10) begin errors++; $display("FAIL flush%0d_annul_start: got %b expected 10", with_ready, {md_annul_o, md_start_o}); end
    @(negedge clk);
    checks++; if (md_annul_o !== 1'b0) begin errors++; $display("FAIL flush%0d_annul_width: got %b expected 0", with_ready, md_annul_o); end
    checks++; if ({hi_o, lo_o} !== {m_hi, m_lo}) begin errors++; $display("FAIL flush%0d_hilo: got %h expected %h", with_ready, {hi_o, lo_o}, {m_hi, m_lo}); end
    #1;
    checks++; if (annul_cnt - a0 !== 1 || done_cnt - d0 !== 0) begin errors++; $display("FAIL flush%0d_counts: got annul=%0d done=%0d expected 1/0", with_ready, annul_cnt - a0, done_cnt - d0); end
  endtask

  task automatic test_idle_flush();
    int d0;
    @(negedge clk);
    d0 = done_cnt;
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    op_i        = 3'b100;
    rs_data_i   = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL idle_flush_stall: got %b expected 0", stall_o); end
    @(negedge clk);
    op_i = 3'b001;
    @(negedge clk);
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    checks++; if ({hi_o, md_start_o, done_o} !== {m_hi, 2'b00}) begin errors++; $display("FAIL idle_flush_ignored: got hi=%h start=%b done=%b expected %h/0/0", hi_o, md_start_o, done_o, m_hi); end
    @(negedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL idle_flush_done: got %0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic [63:0] r;
    bit md, dz;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      unit_lat = $urandom_range(1, c_TIMEOUT - 2);
      md = (op[2] == 1'b0);
      dz = md && op[1] && (b == 32'd0);
      eh = m_hi;
      el = m_lo;
      if (md && !dz) begin
        r  = ref_md(op, a, b);
        eh = r[63:32];
        el = r[31:0];
      end else if (op == 3'b100) begin
        eh = a;
      end else if (op == 3'b101) begin
        el = a;
      end
      run_op(op, a, b, o);
      checks++; if ({o.hi, o.lo} !== {eh, el}) begin errors++; $display("FAIL rand%0d_hilo op=%0d: got %h expected %h", i, op, {o.hi, o.lo}, {eh, el}); end
      checks++; if (o.done_delta !== ((op < 3'd6) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_done op=%0d: got %0d expected %0d", i, op, o.done_delta, (op < 3'd6) ? 1 : 0); end
      checks++; if (o.rises !== ((md && !dz) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_start op=%0d: got %0d expected %0d", i, op, o.rises, (md && !dz) ? 1 : 0); end
      if (md && !dz) begin
        checks++; if ({o.op1, o.op2, o.sel, o.sgn} !== {a, b, ~op[1], ~op[0]}) begin errors++; $display("FAIL rand%0d_issue: got %h expected %h", i, {o.op1, o.op2, o.sel, o.sgn}, {a, b, ~op[1], ~op[0]}); end
        checks++; if (o.stall_acc !== 1'b1 || o.stall_bad !== 0 || o.stall_rdy !== 1'b0) begin errors++; $display("FAIL rand%0d_stall: got %b/%0d/%b expected 1/0/0", i, o.stall_acc, o.stall_bad, o.stall_rdy); end
      end
      m_hi = eh;
      m_lo = el;
    end
  endtask

  task automatic test_timeout();
    int c;
    unit_lat = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    op_i        = 3'b000;
    rs_data_i   = 32'h0000_0007;
    rt_data_i   = 32'h0000_0009;
    @(negedge clk);
    req_valid_i = 1'b0;
    c = 1;
    while (c < 100 && md_annul_o !== 1'b1) begin @(negedge clk); c++; end
    checks++; if (c !== c_TIMEOUT + 1) begin errors++; $display("FAIL timeout_cycle: got annul at %0d expected %0d", c, c_TIMEOUT + 1); end
    checks++; if ({err_o, md_start_o} !== 2'b10) begin errors++; $display("FAIL timeout_err_start: got %b expected 10", {err_o, md_start_o}); end
    @(negedge clk);
    checks++; if ({md_annul_o, err_o} !== 2'b01) begin errors++; $display("FAIL timeout_sticky: got %b expected 01", {md_annul_o, err_o}); end
    checks++; if ({hi_o, lo_o} !== {m_hi, m_lo}) begin errors++; $display("FAIL timeout_hilo: got %h expected %h", {hi_o, lo_o}, {m_hi, m_lo}); end
  endtask

  task automatic test_reset_midbusy();
    unit_lat = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    op_i        = 3'b001;
    rs_data_i   = 32'h1111_2222;
    rt_data_i   = 32'h3333_4444;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if ({md_start_o, stall_o} !== 2'b11) begin errors++; $display("FAIL midbusy_active: got %b expected 11", {md_start_o, stall_o}); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({hi_o, lo_o, md_opdata1_o, md_opdata2_o} !== 128'd0) begin errors++; $display("FAIL midbusy_reset_data: got %h expected 0", {hi_o, lo_o, md_opdata1_o, md_opdata2_o}); end
    checks++; if ({done_o, err_o, md_start_o, md_annul_o, md_sel_mul_div_o, md_signed_o, stall_o} !== 7'd0) begin errors++; $display("FAIL midbusy_reset_ctrl: got %b expected 0000000", {done_o, err_o, md_start_o, md_annul_o, md_sel_mul_div_o, md_signed_o, stall_o}); end
    @(negedge clk);
    checks++; if (md_annul_o !== 1'b0) begin errors++; $display("FAIL midbusy_no_annul: got %b expected 0", md_annul_o); end
    rst = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    unit_lat    = 0;
    m_hi        = 32'd0;
    m_lo        = 32'd0;
    done_cnt    = 0;
    annul_cnt   = 0;
    start_rises = 0;
    low_run     = 0;
    last_gap    = 0;
    prev_start  = 1'b0;
    req_valid_i = 1'b0;
    op_i        = 3'b000;
    rs_data_i   = 32'd0;
    rt_data_i   = 32'd0;
    flush_i     = 1'b0;
    test_reset();
    test_multu();
    test_div();
    test_div0();
    test_back_to_back();
    test_flush(1'b0);
    test_flush(1'b1);
    test_idle_flush();
    test_random();
    test_timeout();
    test_reset_midbusy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
